// File: rtl/fp_convert_unit.sv
// Converts a 12-bit two's-complement integer into an 8-bit S/E/F float
// (value = (-1)^S * F * 2^E). It rounds half-up on the magnitude, saturates
// out-of-range results, and registers the outputs with one cycle of latency.
module fp_convert_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] D,
  output logic        S,
  output logic [2:0]  E,
  output logic [3:0]  F
);

  typedef struct packed {
    logic       sgn;
    logic [2:0] exp;
    logic [3:0] frac;
  } fp8_t;

  logic [11:0] mag;
  logic [3:0]  lead;
  logic [2:0]  exp_raw;
  logic [11:0] shifted;
  logic        rnd;
  logic [4:0]  sum;
  fp8_t        conv;
  fp8_t        conv_q;

  // Negating -2048 wraps back to 0x800. That gives the only case with mag[11] set.
  assign mag = D[11] ? (12'd0 - D) : D;

  // NOTE: every variable assigned in always_comb gets a default first; a
  // path that leaves one unassigned infers a latch.
  always_comb begin
    lead = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (mag[i]) lead = 4'(i);
    end
  end

  // The exponent places the leading one at F[3]. A small magnitude with its
  // leading one at bit 3 or below uses E=0 and needs no rounding.
  always_comb begin
    exp_raw = 3'd0;
    if (lead >= 4'd10)
      exp_raw = 3'd7;
    else if (lead >= 4'd4)
      exp_raw = 3'(lead - 4'd3);
  end

  always_comb begin
    shifted = mag >> exp_raw;
    rnd     = 1'b0;
    if (exp_raw != 3'd0)
      rnd = mag[exp_raw - 3'd1];
    sum = {1'b0, shifted[3:0]} + {4'd0, rnd};
  end

  always_comb begin
    conv.sgn  = D[11];
    conv.exp  = exp_raw;
    conv.frac = sum[3:0];
    if (mag[11]) begin
      conv.exp  = 3'd7;
      conv.frac = 4'd15;
    end else if (sum[4]) begin
      // Rounding carried out of F. Renormalise to 1000 one exponent up, or
      // clamp to the largest value if the exponent is already at the top.
      if (exp_raw == 3'd7) begin
        conv.exp  = 3'd7;
        conv.frac = 4'd15;
      end else begin
        conv.exp  = exp_raw + 3'd1;
        conv.frac = 4'd8;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples its inputs from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      conv_q <= '0;
    else
      conv_q <= conv;
  end

  assign S = conv_q.sgn;
  assign E = conv_q.exp;
  assign F = conv_q.frac;

endmodule

// File: tb/tb_fp_convert_unit.sv
// Self-checking bench for fp_convert_unit. It checks directed vectors with
// hand-computed results, then runs a full sweep against an arithmetic reference.
module tb_fp_convert_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] d;
  logic        s;
  logic [2:0]  e;
  logic [3:0]  f;

  int errors = 0;
  int checks = 0;

  fp_convert_unit dut (
    .clk  (clk),
    .rst_n(rst_n),
    .D    (d),
    .S    (s),
    .E    (e),
    .F    (f)
  );

  always #5 clk = ~clk;

  // Each call advances one rising edge and leaves the bench 1 time unit after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // This reference is written in integer arithmetic. It picks the smallest
  // exponent where the magnitude fits in 4 bits, then rounds by adding half an LSB.
  function automatic logic [7:0] ref_conv(input int val);
    int   mag;
    int   ex;
    int   fr;
    logic sg;
    sg  = (val < 0);
    mag = sg ? -val : val;
    if (mag >= 2048) return {sg, 3'd7, 4'd15};
    ex = 0;
    while (ex < 7 && (mag >> ex) > 15) ex++;
    fr = (mag + ((ex > 0) ? (1 << (ex - 1)) : 0)) >> ex;
    if (fr == 16) begin
      if (ex == 7) return {sg, 3'd7, 4'd15};
      ex = ex + 1;
      fr = 8;
    end
    return {sg, ex[2:0], fr[3:0]};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    d     = 12'd422;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if ({s, e, f} !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %b_%b_%b, want 0_000_0000", i, s, e, f);
      end
    end
    rst_n = 1'b1;
    cycle();
    checks++;
    if ({s, e, f} !== {1'b0, 3'd5, 4'd13}) begin
      errors++;
      $display("FAIL reset_release: got %b_%0d_%0d, want 0_5_13", s, e, f);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] vec [5];
    logic [7:0]  exp_v [5];
    vec   = '{12'd0, -12'sd40, 12'd56, 12'd416, 12'd215};
    exp_v = '{{1'b0, 3'd0, 4'd0}, {1'b1, 3'd2, 4'd10}, {1'b0, 3'd2, 4'd14},
              {1'b0, 3'd5, 4'd13}, {1'b0, 3'd4, 4'd13}};
    for (int i = 0; i < 5; i++) begin
      d = vec[i];
      cycle();
      checks++;
      if ({s, e, f} !== exp_v[i]) begin
        errors++;
        $display("FAIL seq[%0d] D=%0d: got %h, want %h", i, $signed(vec[i]), {s, e, f}, exp_v[i]);
      end
    end
  endtask

  task automatic test_directed(input string name, input int val, input logic [7:0] want);
    d = val[11:0];
    cycle();
    checks++;
    if ({s, e, f} !== want) begin
      errors++;
      $display("FAIL %s D=%0d: got S=%b E=%0d F=%0d, want S=%b E=%0d F=%0d",
               name, val, s, e, f, want[7], want[6:4], want[3:0]);
    end
  endtask

  task automatic test_rounding();
    test_directed("round_carry", 125, {1'b0, 3'd4, 4'd8});
    test_directed("round_up",     46, {1'b0, 3'd2, 4'd12});
  endtask

  task automatic test_saturation();
    test_directed("sat_max",    2047, {1'b0, 3'd7, 4'd15});
    test_directed("sat_min",   -2048, {1'b1, 3'd7, 4'd15});
    test_directed("sat_carry",  1984, {1'b0, 3'd7, 4'd15});
  endtask

  task automatic test_small();
    test_directed("small_15", 15, {1'b0, 3'd0, 4'd15});
    test_directed("small_m1", -1, {1'b1, 3'd0, 4'd1});
    test_directed("small_16", 16, {1'b0, 3'd1, 4'd8});
  endtask

  // A change of D between edges must not show up on the registered outputs.
  task automatic test_mid_cycle();
    d = 12'd416;
    cycle();
    #2;
    d = 12'd15;
    #1;
    checks++;
    if ({s, e, f} !== {1'b0, 3'd5, 4'd13}) begin
      errors++;
      $display("FAIL mid_cycle_hold: got %h, want %h", {s, e, f}, {1'b0, 3'd5, 4'd13});
    end
    cycle();
    checks++;
    if ({s, e, f} !== {1'b0, 3'd0, 4'd15}) begin
      errors++;
      $display("FAIL mid_cycle_next: got %h, want %h", {s, e, f}, {1'b0, 3'd0, 4'd15});
    end
  endtask

  task automatic test_async_reset();
    d = -12'sd40;
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s, e, f} !== 8'h00) begin
      errors++;
      $display("FAIL async_clear: got %h, want 00", {s, e, f});
    end
    cycle();
    checks++;
    if ({s, e, f} !== 8'h00) begin
      errors++;
      $display("FAIL async_hold: got %h, want 00", {s, e, f});
    end
    rst_n = 1'b1;
    cycle();
    checks++;
    if ({s, e, f} !== {1'b1, 3'd2, 4'd10}) begin
      errors++;
      $display("FAIL async_release: got %h, want %h", {s, e, f}, {1'b1, 3'd2, 4'd10});
    end
  endtask

  task automatic test_sweep();
    logic [7:0] want;
    for (int v = -2048; v <= 2047; v++) begin
      d    = v[11:0];
      want = ref_conv(v);
      cycle();
      checks++;
      if ({s, e, f} !== want) begin
        errors++;
        $display("FAIL sweep D=%0d: got %h, want %h", v, {s, e, f}, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_rounding();
    test_saturation();
    test_small();
    test_mid_cycle();
    test_async_reset();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
